// File: rtl/control_sequencer.sv
// Hard-wired fetch/execute sequencer for 3-operand ALU instructions, with halt/start control,
// a memory-wait timeout and a retired-instruction counter.
module control_sequencer #(
  parameter int unsigned NUM_REGS    = 16,
  parameter int unsigned MEM_TIMEOUT = 15
) (
  input  logic                Clock,
  input  logic                Reset_n,
  input  logic                Start,
  input  logic                Stop,
  input  logic [31:0]         IR_Q,
  input  logic                Mem_Ready,
  output logic                PC_Out,
  output logic                MAR_In,
  output logic                IncPC,
  output logic                PC_In,
  output logic                Read,
  output logic                MDR_In,
  output logic                MDR_Out,
  output logic                IR_In,
  output logic                Y_In,
  output logic                Z_In,
  output logic                ZLO_Out,
  output logic [4:0]          CONTROL,
  output logic [NUM_REGS-1:0] R_In,
  output logic [NUM_REGS-1:0] R_Out,
  output logic                Run,
  output logic                Fault,
  output logic [31:0]         Instr_Count
);

  typedef enum logic [3:0] {
    StHalt, StT0, StT1, StT2, StT3, StT4, StT5, StT6, StFault
  } state_e;

  state_e      state_q;
  logic [3:0]  wait_q;
  logic [31:0] count_q;

  logic [4:0] op;
  logic [3:0] ra, rb, rc;
  logic       is_alu, is_nop, is_halt;
  logic       unused_ir;

  assign op        = IR_Q[31:27];
  assign ra        = IR_Q[26:23];
  assign rb        = IR_Q[22:19];
  assign rc        = IR_Q[18:15];
  assign unused_ir = ^IR_Q[14:0];
  assign is_alu    = (op <= 5'h0C);
  assign is_nop    = (op == 5'h1A);
  assign is_halt   = (op == 5'h1B);

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= StHalt;
      wait_q  <= '0;
      count_q <= '0;
    end else begin
      unique case (state_q)
        StHalt: if (Start) state_q <= StT0;
        StT0:   state_q <= StT1;
        StT1:   state_q <= StT2;
        StT2: begin
          if (Mem_Ready) begin
            state_q <= StT3;
            wait_q  <= '0;
          end else if (wait_q == 4'(MEM_TIMEOUT - 1)) begin
            state_q <= StFault;
            wait_q  <= '0;
          end else begin
            wait_q <= wait_q + 4'd1;
          end
        end
        StT3: state_q <= StT4;
        StT4: begin
          if (is_alu) begin
            state_q <= StT5;
          end else if (is_nop || is_halt) begin
            count_q <= count_q + 32'd1;
            state_q <= (Stop || is_halt) ? StHalt : StT0;
          end else begin
            state_q <= StFault;
          end
        end
        StT5: state_q <= StT6;
        StT6: begin
          count_q <= count_q + 32'd1;
          state_q <= Stop ? StHalt : StT0;
        end
        StFault: state_q <= StFault;
        default: state_q <= StHalt;
      endcase
    end
  end

  // Strobes decode from state; T4/T5/T6 also use the IR fields, which are stable from T4 on.
  always_comb begin
    PC_Out  = 1'b0;
    MAR_In  = 1'b0;
    IncPC   = 1'b0;
    PC_In   = 1'b0;
    Read    = 1'b0;
    MDR_In  = 1'b0;
    MDR_Out = 1'b0;
    IR_In   = 1'b0;
    Y_In    = 1'b0;
    Z_In    = 1'b0;
    ZLO_Out = 1'b0;
    CONTROL = 5'd0;
    R_In    = '0;
    R_Out   = '0;
    unique case (state_q)
      StT0: begin
        PC_Out = 1'b1;
        MAR_In = 1'b1;
        IncPC  = 1'b1;
        Z_In   = 1'b1;
      end
      StT1: begin
        ZLO_Out = 1'b1;
        PC_In   = 1'b1;
      end
      StT2: begin
        Read   = 1'b1;
        MDR_In = Mem_Ready;
      end
      StT3: begin
        MDR_Out = 1'b1;
        IR_In   = 1'b1;
      end
      StT4: begin
        if (is_alu) begin
          R_Out = NUM_REGS'(1) << rb;
          Y_In  = 1'b1;
        end
      end
      StT5: begin
        R_Out   = NUM_REGS'(1) << rc;
        CONTROL = op;
        Z_In    = 1'b1;
      end
      StT6: begin
        ZLO_Out = 1'b1;
        R_In    = NUM_REGS'(1) << ra;
      end
      default: ;
    endcase
  end

  assign Run         = (state_q != StHalt) && (state_q != StFault);
  assign Fault       = (state_q == StFault);
  assign Instr_Count = count_q;

endmodule
